// File: rtl/ysyx_23060332_idu_pipe.sv
// ysyx_23060332_idu_pipe: registered RV32I/RV64I decode stage between IFU and EXU.
// The instruction is decoded combinationally from in_inst/rdata* and captured into
// a one-entry output register with a valid/ready handshake and flush.
// Illegal encodings and EBREAK are reported as flags and never trap here.
// Optional feature macro: IDU_SCOREBOARD_EN (per-register pending-write counters
// that stall issue on RAW hazards and on a saturated destination counter).
module ysyx_23060332_idu_pipe #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int SB_CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] raddr1,
    output logic [REG_AW-1:0] raddr2,
    input  logic [XLEN-1:0]   rdata1,
    input  logic [XLEN-1:0]   rdata2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_inst,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_jop1,
    output logic [XLEN-1:0]   out_jop2,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic              out_wen,
    output logic [REG_AW-1:0] out_waddr,
    output logic [3:0]        out_alu_op,
    output logic [2:0]        out_br_type,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [1:0]        out_mem_size,
    output logic              out_mem_uns,
    output logic              out_illegal,
    output logic              out_ebreak,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [31:0]       inst;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   jop1;
        logic [XLEN-1:0]   jop2;
        logic [XLEN-1:0]   rs2_data;
        logic              wen;
        logic [REG_AW-1:0] waddr;
        logic [3:0]        alu_op;
        logic [2:0]        br_type;
        logic              mem_rd;
        logic              mem_wr;
        logic [1:0]        mem_size;
        logic              mem_uns;
        logic              illegal;
        logic              ebreak;
    } pkt_t;

    // 32-bit immediate sign-extended to the datapath width.
    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // func3 -> ALU op; alt selects SUB/SRA (only meaningful for R-type ADD and shifts right).
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt_add, input logic alt_sr);
        case (f3)
            3'b000:  alu_of = alt_add ? 4'd1 : 4'd0;
            3'b001:  alu_of = 4'd2;
            3'b010:  alu_of = 4'd3;
            3'b011:  alu_of = 4'd4;
            3'b100:  alu_of = 4'd5;
            3'b101:  alu_of = alt_sr ? 4'd7 : 4'd6;
            3'b110:  alu_of = 4'd8;
            default: alu_of = 4'd9;
        endcase
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = in_inst[6:0];
    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign rs1_f = in_inst[19:15];
    assign rs2_f = in_inst[24:20];
    assign rd_f  = in_inst[11:7];
    assign imm_i = sx({{20{in_inst[31]}}, in_inst[31:20]});
    assign imm_s = sx({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
    assign imm_b = sx({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0});
    assign imm_u = sx({in_inst[31:12], 12'b0});
    assign imm_j = sx({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0});

    pkt_t pkt_d, pkt_q;
    logic out_valid_q;
    logic use1, use2;
    logic stall, accept;

    // Combinational decode of the incoming instruction into a packet.
    always_comb begin
        logic ill, wen;
        pkt_d      = '0;
        pkt_d.pc   = in_pc;
        pkt_d.inst = in_inst;
        use1 = 1'b0;
        use2 = 1'b0;
        ill  = 1'b0;
        wen  = 1'b0;
        case (opc)
            OPC_LUI: begin
                pkt_d.op1 = imm_u;
                wen = 1'b1;
            end
            OPC_AUIPC: begin
                pkt_d.op1 = in_pc;
                pkt_d.op2 = imm_u;
                wen = 1'b1;
            end
            OPC_JAL: begin
                pkt_d.op1     = in_pc;
                pkt_d.op2     = XLEN'(4);
                pkt_d.jop1    = in_pc;
                pkt_d.jop2    = imm_j;
                pkt_d.br_type = 3'd7;
                wen = 1'b1;
            end
            OPC_JALR: begin
                use1 = 1'b1;
                pkt_d.op1     = in_pc;
                pkt_d.op2     = XLEN'(4);
                pkt_d.jop1    = rdata1;
                pkt_d.jop2    = imm_i;
                pkt_d.br_type = 3'd7;
                wen = 1'b1;
                ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
                pkt_d.op1      = rdata1;
                pkt_d.op2      = rdata2;
                pkt_d.rs2_data = rdata2;
                pkt_d.jop1     = in_pc;
                pkt_d.jop2     = imm_b;
                case (f3)
                    3'b000:  pkt_d.br_type = 3'd1;
                    3'b001:  pkt_d.br_type = 3'd2;
                    3'b100:  pkt_d.br_type = 3'd3;
                    3'b101:  pkt_d.br_type = 3'd4;
                    3'b110:  pkt_d.br_type = 3'd5;
                    3'b111:  pkt_d.br_type = 3'd6;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use1 = 1'b1;
                pkt_d.op1      = rdata1;
                pkt_d.op2      = imm_i;
                pkt_d.mem_rd   = 1'b1;
                pkt_d.mem_size = f3[1:0];
                pkt_d.mem_uns  = f3[2];
                wen = 1'b1;
                // LD and LWU exist only on RV64; f3=111 never exists.
                case (f3)
                    3'b011, 3'b110: ill = (XLEN != 64);
                    3'b111:         ill = 1'b1;
                    default:        ill = 1'b0;
                endcase
            end
            OPC_STORE: begin
                use1 = 1'b1;
                use2 = 1'b1;
                pkt_d.op1      = rdata1;
                pkt_d.op2      = imm_s;
                pkt_d.rs2_data = rdata2;
                pkt_d.mem_wr   = 1'b1;
                pkt_d.mem_size = f3[1:0];
                if (f3 == 3'b011) ill = (XLEN != 64);
                else              ill = f3[2];
            end
            OPC_OPIMM: begin
                use1 = 1'b1;
                pkt_d.op1    = rdata1;
                pkt_d.op2    = imm_i;
                pkt_d.alu_op = alu_of(f3, 1'b0, in_inst[30]);
                wen = 1'b1;
                // Shift immediates: upper bits must be 0 (or 0100000 for SRAI);
                // shamt[5] is only meaningful on RV64.
                if (f3 == 3'b001)
                    ill = (in_inst[31:26] != 6'b0) || (XLEN != 64 && in_inst[25]);
                else if (f3 == 3'b101)
                    ill = (in_inst[31:26] != 6'b0 && in_inst[31:26] != 6'b010000) ||
                          (XLEN != 64 && in_inst[25]);
            end
            OPC_OP: begin
                use1 = 1'b1;
                use2 = 1'b1;
                pkt_d.op1    = rdata1;
                pkt_d.op2    = rdata2;
                pkt_d.alu_op = alu_of(f3, in_inst[30], in_inst[30]);
                wen = 1'b1;
                ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_SYSTEM: begin
                if (in_inst == EBREAK) pkt_d.ebreak = 1'b1;
                else                   ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // RV32E: registers above x15 do not exist.
        if (REG_AW < 5)
            if ((use1 && rs1_f[4]) || (use2 && rs2_f[4]) || (wen && rd_f[4])) ill = 1'b1;
        pkt_d.waddr   = rd_f[REG_AW-1:0];
        pkt_d.wen     = wen && !ill && (rd_f != 5'd0);
        pkt_d.illegal = ill;
        if (ill) begin
            pkt_d.mem_rd  = 1'b0;
            pkt_d.mem_wr  = 1'b0;
            pkt_d.br_type = 3'd0;
        end
    end

    assign raddr1 = use1 ? rs1_f[REG_AW-1:0] : '0;
    assign raddr2 = use2 ? rs2_f[REG_AW-1:0] : '0;

    assign in_ready = (!out_valid_q || out_ready) && !stall && !flush;
    assign accept   = in_valid && in_ready;

`ifdef IDU_SCOREBOARD_EN
    localparam int NREG = 1 << REG_AW;
    logic [NREG-1:0][SB_CNT_W-1:0] cnt_q, cnt_d;
    logic inc_en, wb_en, fl_en;

    assign inc_en = accept && pkt_d.wen;
    assign wb_en  = wb_valid && (wb_addr != '0);
    assign fl_en  = flush && out_valid_q && pkt_q.wen;

    // Hazard: a source still has an outstanding write, or rd's counter cannot grow.
    assign stall = (use1 && (raddr1 != '0) && (cnt_q[raddr1] != '0)) ||
                   (use2 && (raddr2 != '0) && (cnt_q[raddr2] != '0)) ||
                   (pkt_d.wen && (cnt_q[pkt_d.waddr] == '1));

    // Per-register counter update: +1 on issue, -1 per retire and per squashed packet.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NREG; r++) begin
            logic up;
            logic [1:0] dn;
            up = inc_en && (pkt_d.waddr == REG_AW'(r));
            dn = {1'b0, wb_en && (wb_addr == REG_AW'(r))} +
                 {1'b0, fl_en && (pkt_q.waddr == REG_AW'(r))};
            if (up && dn == 2'd0) begin
                if (cnt_q[r] != '1) cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (!up && dn != 2'd0) begin
                if (cnt_q[r] == '0)                            cnt_d[r] = '0;
                else if (dn == 2'd2 && cnt_q[r] > SB_CNT_W'(1)) cnt_d[r] = cnt_q[r] - SB_CNT_W'(2);
                else if (dn == 2'd2)                            cnt_d[r] = '0;
                else                                            cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    // Scoreboard state; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_sb;
    assign unused_sb = ^{wb_valid, wb_addr, SB_CNT_W[0]};
    assign stall     = 1'b0;
`endif

    // Output pipeline register: flush squashes, accept loads, a consumed packet retires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            pkt_q       <= pkt_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = pkt_q.pc;
    assign out_inst     = pkt_q.inst;
    assign out_op1      = pkt_q.op1;
    assign out_op2      = pkt_q.op2;
    assign out_jop1     = pkt_q.jop1;
    assign out_jop2     = pkt_q.jop2;
    assign out_rs2_data = pkt_q.rs2_data;
    assign out_wen      = pkt_q.wen;
    assign out_waddr    = pkt_q.waddr;
    assign out_alu_op   = pkt_q.alu_op;
    assign out_br_type  = pkt_q.br_type;
    assign out_mem_rd   = pkt_q.mem_rd;
    assign out_mem_wr   = pkt_q.mem_wr;
    assign out_mem_size = pkt_q.mem_size;
    assign out_mem_uns  = pkt_q.mem_uns;
    assign out_illegal  = pkt_q.illegal;
    assign out_ebreak   = pkt_q.ebreak;

endmodule
